// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline interlock controller for the 5-stage core.
// Handles load-use stalls, multdiv occupancy of X (IDLE/RUN/DONE FSM with a
// timeout abort) and taken-branch flushes of the F/D latch.
// Optional build macro HAZARD_PERF_EN adds saturating performance counters.
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_X,
    input  logic        branch_taken,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        stall_FD,
    output logic        stall_DX,
    output logic        nop_XM,
    output logic        nop_DX,
    output logic        flush_FD,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic        md_error
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_md_cycles,
    output logic [31:0] perf_flushes
`endif
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt, next_cnt;
    logic              err_set;
    logic              lu_evt;
    logic              fl_evt;

    // Instruction fields used by the interlock; the X/M latch consumes
    // md_exception directly, so it is not needed here.
    logic [4:0] op_d, rd_d, rs_d, rt_d;
    logic [4:0] op_x, rd_x, alu_x;
    logic       unused_bits;

    assign op_d  = IR_D[31:27];
    assign rd_d  = IR_D[26:22];
    assign rs_d  = IR_D[21:17];
    assign rt_d  = IR_D[16:12];
    assign op_x  = IR_X[31:27];
    assign rd_x  = IR_X[26:22];
    assign alu_x = IR_X[6:2];
    assign unused_bits = ^{IR_D[11:0], IR_X[21:7], IR_X[1:0], md_exception};

    logic x_is_md;
    logic x_is_lw;
    logic reads_rd, reads_rs, reads_rt;
    logic load_use;

    assign x_is_md = (op_x == OP_RTYPE) && ((alu_x == ALU_MUL) || (alu_x == ALU_DIV));
    // A load into r0 never produces a value, so it never creates a dependency.
    assign x_is_lw = (op_x == OP_LW) && (rd_x != 5'd0);

    // Source registers read by the instruction in decode; sw data is forwarded W->M.
    always_comb begin
        reads_rd = 1'b0;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        case (op_d)
            OP_RTYPE: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_ADDI, OP_LW, OP_SW, OP_JR, OP_BEX: reads_rs = 1'b1;
            OP_BNE, OP_BLT: begin
                reads_rd = 1'b1;
                reads_rs = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_use = x_is_lw && ((reads_rd && (rd_d == rd_x)) ||
                                  (reads_rs && (rs_d == rd_x)) ||
                                  (reads_rt && (rt_d == rd_x)));

    // Next-state and control outputs; priority is multdiv > flush > load-use,
    // and every control is forced low while reset is held.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        next_cnt   = cnt;
        err_set    = 1'b0;
        lu_evt     = 1'b0;
        fl_evt     = 1'b0;
        stall_FD   = 1'b0;
        stall_DX   = 1'b0;
        nop_XM     = 1'b0;
        nop_DX     = 1'b0;
        flush_FD   = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        md_done    = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (x_is_md) begin
                        next_state = RUN;
                        next_cnt   = '0;
                        md_start   = 1'b1;
                        stall_FD   = 1'b1;
                        stall_DX   = 1'b1;
                        nop_XM     = 1'b1;
                    end else if (branch_taken) begin
                        flush_FD = 1'b1;
                        nop_DX   = 1'b1;
                        fl_evt   = 1'b1;
                    end else if (load_use) begin
                        stall_FD = 1'b1;
                        nop_DX   = 1'b1;
                        lu_evt   = 1'b1;
                    end
                end
                RUN: begin
                    md_busy  = 1'b1;
                    stall_FD = 1'b1;
                    stall_DX = 1'b1;
                    nop_XM   = 1'b1;
                    next_cnt = cnt + CNT_W'(1);
                    if (md_ready) begin
                        next_state = DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Timeout: kill the stuck instruction and give X back.
                        err_set    = 1'b1;
                        nop_DX     = 1'b1;
                        next_state = IDLE;
                    end
                end
                DONE: begin
                    md_done    = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // FSM state, multdiv cycle counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            md_error <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= next_state;
            cnt   <= next_cnt;
            if (err_set) begin
                md_error <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters for load-use stalls, busy cycles and flushes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_lu_stalls <= '0;
            perf_md_cycles <= '0;
            perf_flushes   <= '0;
        end else begin
            if (lu_evt && (perf_lu_stalls != '1)) perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (md_busy && (perf_md_cycles != '1)) perf_md_cycles <= perf_md_cycles + 32'd1;
            if (fl_evt && (perf_flushes != '1)) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`else
    logic unused_evts;
    assign unused_evts = lu_evt ^ fl_evt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors for hazard_stall_ctrl. The stimulus
// process queues the expected control vector for each cycle; a monitor pops
// and compares on the falling edge.
module tb_hazard_stall_ctrl;

    localparam logic [8:0] SFD = 9'h100;
    localparam logic [8:0] SDX = 9'h080;
    localparam logic [8:0] NXM = 9'h040;
    localparam logic [8:0] NDX = 9'h020;
    localparam logic [8:0] FFD = 9'h010;
    localparam logic [8:0] STA = 9'h008;
    localparam logic [8:0] BSY = 9'h004;
    localparam logic [8:0] DON = 9'h002;
    localparam logic [8:0] ERR = 9'h001;
    localparam logic [8:0] S3  = SFD | SDX | NXM;

    logic        clock = 1'b1;
    logic        reset;
    logic [31:0] ir_d, ir_x;
    logic        branch_taken, md_ready, md_exception;
    logic        stall_FD, stall_DX, nop_XM, nop_DX, flush_FD;
    logic        md_start, md_busy, md_done, md_error;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_stalls, perf_md_cycles, perf_flushes;
`endif

    hazard_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .IR_D        (ir_d),
        .IR_X        (ir_x),
        .branch_taken(branch_taken),
        .md_ready    (md_ready),
        .md_exception(md_exception),
        .stall_FD    (stall_FD),
        .stall_DX    (stall_DX),
        .nop_XM      (nop_XM),
        .nop_DX      (nop_DX),
        .flush_FD    (flush_FD),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .md_error    (md_error)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_stalls(perf_lu_stalls),
        .perf_md_cycles(perf_md_cycles),
        .perf_flushes  (perf_flushes)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } item_t;

    item_t q[$];
    item_t cur;
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, rd, rs);
        return {op, rd, rs, 17'd0};
    endfunction

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            n_tests++;
            if ({stall_FD, stall_DX, nop_XM, nop_DX, flush_FD,
                 md_start, md_busy, md_done, md_error} !== cur.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (sFD sDX nXM nDX fFD start busy done err)",
                         cur.name,
                         {stall_FD, stall_DX, nop_XM, nop_DX, flush_FD,
                          md_start, md_busy, md_done, md_error}, cur.exp);
            end
        end
    end

    task automatic step(input logic [31:0] d, x, input logic bt, rdy,
                        input logic [8:0] exp, input string nm);
        ir_d         = d;
        ir_x         = x;
        branch_taken = bt;
        md_ready     = rdy;
        q.push_back('{nm, exp});
        @(posedge clock);
        #1;
    endtask

    logic [31:0] nop_i, add_i, lw5, lw0, sw5, bne5, addi5, mul_i, mul2, div_i;

    initial begin
        nop_i = 32'h0;
        add_i = rtype(5'd6, 5'd5, 5'd2, 5'd0);
        lw5   = itype(5'b01000, 5'd5, 5'd3);
        lw0   = itype(5'b01000, 5'd0, 5'd3);
        sw5   = itype(5'b00111, 5'd5, 5'd3);
        bne5  = itype(5'b00010, 5'd5, 5'd1);
        addi5 = itype(5'b00101, 5'd5, 5'd1);
        mul_i = rtype(5'd7, 5'd1, 5'd2, 5'b00110);
        mul2  = rtype(5'd8, 5'd3, 5'd4, 5'b00110);
        div_i = rtype(5'd9, 5'd1, 5'd2, 5'b00111);
        md_exception = 1'b0;

        // Reset held with a mul in X: everything must stay low.
        reset = 1'b0;
        step(nop_i, mul_i, 1'b0, 1'b0, 9'h000, "rst_hold");
        reset = 1'b1;

        // Load-use detection.
        step(add_i, lw5, 1'b0, 1'b0, SFD | NDX, "lu_rs");
        step(add_i, nop_i, 1'b0, 1'b1, 9'h000, "lu_drop_ready_idle");
        step(add_i, nop_i, 1'b0, 1'b0, 9'h000, "ready_ignored_idle");
        step(rtype(5'd6, 5'd0, 5'd2, 5'd0), lw0, 1'b0, 1'b0, 9'h000, "lu_r0");
        step(sw5, lw5, 1'b0, 1'b0, 9'h000, "lu_sw_data");
        step(rtype(5'd6, 5'd2, 5'd5, 5'd0), lw5, 1'b0, 1'b0, SFD | NDX, "lu_rt");
        step(bne5, lw5, 1'b0, 1'b0, SFD | NDX, "lu_bne_rd");
        step(addi5, lw5, 1'b0, 1'b0, 9'h000, "lu_addi_rd");

        // Branch flush, alone and against a load-use hazard.
        step(add_i, lw5, 1'b1, 1'b0, FFD | NDX, "br_over_lu");
        step(nop_i, nop_i, 1'b1, 1'b0, FFD | NDX, "br");

        // mul with ready on the 5th RUN cycle, second mul waiting in D.
        step(mul2, mul_i, 1'b0, 1'b0, S3 | STA, "mul_start");
        step(mul2, mul_i, 1'b0, 1'b0, S3 | BSY, "mul_run1");
        step(mul2, mul_i, 1'b1, 1'b0, S3 | BSY, "mul_run2_br_ignored");
        step(mul2, mul_i, 1'b0, 1'b0, S3 | BSY, "mul_run3");
        step(mul2, mul_i, 1'b0, 1'b0, S3 | BSY, "mul_run4");
        step(mul2, mul_i, 1'b0, 1'b1, S3 | BSY, "mul_run5_ready");
        step(add_i, lw5, 1'b1, 1'b1, DON, "mul_done_no_lu_no_br");
        step(nop_i, mul2, 1'b0, 1'b0, S3 | STA, "mul2_start");
        step(nop_i, mul2, 1'b0, 1'b1, S3 | BSY, "mul2_run_ready");
        step(nop_i, mul2, 1'b0, 1'b0, DON, "mul2_done");
        step(nop_i, nop_i, 1'b0, 1'b0, 9'h000, "idle_after_mul2");

        // div that never completes: 8 RUN cycles then abort.
        step(nop_i, div_i, 1'b0, 1'b0, S3 | STA, "div_start");
        for (int i = 0; i < 7; i++) begin
            step(nop_i, div_i, 1'b0, 1'b0, S3 | BSY, "div_run");
        end
        step(nop_i, div_i, 1'b0, 1'b0, S3 | BSY | NDX, "div_timeout");
        step(nop_i, nop_i, 1'b0, 1'b0, ERR, "div_err_set");
        step(add_i, lw5, 1'b0, 1'b0, SFD | NDX | ERR, "err_sticky_lu");

        // Reset in the middle of RUN (counter at 3).
        step(nop_i, mul_i, 1'b0, 1'b0, S3 | STA | ERR, "mul_b_start");
        for (int i = 0; i < 3; i++) begin
            step(nop_i, mul_i, 1'b0, 1'b0, S3 | BSY | ERR, "mul_b_run");
        end
        reset = 1'b0;
        step(nop_i, mul_i, 1'b0, 1'b0, 9'h000, "rst_mid_run");
        step(nop_i, mul_i, 1'b0, 1'b1, 9'h000, "rst_still_low");
        reset = 1'b1;
        step(add_i, add_i, 1'b0, 1'b0, 9'h000, "post_rst_add");
        step(nop_i, add_i, 1'b0, 1'b0, 9'h000, "post_rst_idle");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
